// File: rtl/ram_arbiter.sv
// Arbiter sharing the 4096x4 microcode RAM between the uP core (port C) and the debug/loader port (D).
// One registered access per cycle keeps adr/wrte/data stable over the whole enable window.
module ram_arbiter #(
  parameter int AW       = 12,
  parameter int DW       = 4,
  parameter bit PRIO_CPU = 1'b0,
  parameter int LOCK_MAX = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          c_req,
  input  logic          c_we,
  input  logic          c_lock,
  input  logic [AW-1:0] c_addr,
  input  logic [DW-1:0] c_wdata,
  output logic          c_gnt,
  output logic          c_rvalid,
  input  logic          d_req,
  input  logic          d_we,
  input  logic          d_lock,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] rdata,
  output logic          ram_chips,
  output logic          ram_wrte,
  output logic [AW-1:0] ram_adr,
  output logic [DW-1:0] ram_dout,
  output logic          ram_drv,
  input  logic [DW-1:0] ram_din
);

  typedef enum logic {IDLE, ACC} state_e;
  typedef enum logic {SEL_C = 1'b0, SEL_D = 1'b1} sel_e;

  localparam logic [3:0] LOCK_LAST = 4'(LOCK_MAX - 1);

  state_e          state_q, state_d;
  sel_e            last_q, last_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            grant, locked, own_req, own_lock, rd_done;
  logic            sel_we;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_wdata;

  logic            c_gnt_q, d_gnt_q, c_rvalid_q, d_rvalid_q;
  logic            chips_q, wrte_q, drv_q;
  logic [AW-1:0]   adr_q;
  logic [DW-1:0]   dout_q, rdata_q;

  // last_q names the owner of the access currently on the RAM while in ACC.
  assign own_req  = (last_q == SEL_C) ? c_req  : d_req;
  assign own_lock = (last_q == SEL_C) ? c_lock : d_lock;
  assign locked   = (state_q == ACC) && own_req && own_lock && (cnt_q < LOCK_LAST);
  assign rd_done  = (state_q == ACC) && !wrte_q;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    grant   = 1'b0;
    last_d  = last_q;
    cnt_d   = cnt_q;
    state_d = IDLE;
    if (locked) begin
      grant = 1'b1;
      cnt_d = cnt_q + 4'd1;
    end else if (c_req && d_req) begin
      grant  = 1'b1;
      last_d = PRIO_CPU ? SEL_C : ((last_q == SEL_C) ? SEL_D : SEL_C);
    end else if (c_req || d_req) begin
      grant  = 1'b1;
      last_d = c_req ? SEL_C : SEL_D;
    end
    if (grant && !locked && (last_d != last_q)) cnt_d = '0;
    if (grant) state_d = ACC;
  end

  assign sel_we    = (last_d == SEL_C) ? c_we    : d_we;
  assign sel_addr  = (last_d == SEL_C) ? c_addr  : d_addr;
  assign sel_wdata = (last_d == SEL_C) ? c_wdata : d_wdata;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      last_q     <= SEL_D;
      cnt_q      <= '0;
      c_gnt_q    <= 1'b0;
      d_gnt_q    <= 1'b0;
      c_rvalid_q <= 1'b0;
      d_rvalid_q <= 1'b0;
      chips_q    <= 1'b0;
      wrte_q     <= 1'b0;
      drv_q      <= 1'b0;
      adr_q      <= '0;
      dout_q     <= '0;
      rdata_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q    <= state_d;
      last_q     <= last_d;
      cnt_q      <= cnt_d;
      c_gnt_q    <= grant && (last_d == SEL_C);
      d_gnt_q    <= grant && (last_d == SEL_D);
      chips_q    <= grant;
      wrte_q     <= grant && sel_we;
      drv_q      <= grant && sel_we;
      if (grant) begin
        adr_q  <= sel_addr;
        dout_q <= sel_wdata;
      end
      // A read completes at the end of its ACC cycle; its data lands with the next grant.
      c_rvalid_q <= rd_done && (last_q == SEL_C);
      d_rvalid_q <= rd_done && (last_q == SEL_D);
      if (rd_done) rdata_q <= ram_din;
    end
  end

  assign c_gnt     = c_gnt_q;
  assign d_gnt     = d_gnt_q;
  assign c_rvalid  = c_rvalid_q;
  assign d_rvalid  = d_rvalid_q;
  assign rdata     = rdata_q;
  assign ram_chips = chips_q;
  assign ram_wrte  = wrte_q;
  assign ram_adr   = adr_q;
  assign ram_dout  = dout_q;
  assign ram_drv   = drv_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: a round-robin instance (LOCK_MAX=4) and a CPU-priority instance (LOCK_MAX=3)
// share one stimulus stream and are checked every cycle against a behavioural arbiter/RAM model.
module tb_ram_arbiter;
  localparam int AW = 12;
  localparam int DW = 4;

  typedef struct packed {
    logic          c_gnt;
    logic          d_gnt;
    logic          c_rvalid;
    logic          d_rvalid;
    logic [DW-1:0] rdata;
    logic          chips;
    logic          wrte;
    logic [AW-1:0] adr;
    logic [DW-1:0] dout;
    logic          drv;
  } obs_t;

  logic clk, reset;
  logic c_req, c_we, c_lock, d_req, d_we, d_lock;
  logic [AW-1:0] c_addr, d_addr;
  logic [DW-1:0] c_wdata, d_wdata;

  logic c_gnt0, d_gnt0, c_rv0, d_rv0, chips0, wrte0, drv0;
  logic c_gnt1, d_gnt1, c_rv1, d_rv1, chips1, wrte1, drv1;
  logic [AW-1:0] adr0, adr1;
  logic [DW-1:0] rdata0, dout0, din0, rdata1, dout1, din1;

  logic [DW-1:0] fx0 [4096];
  logic [DW-1:0] fx1 [4096];

  int checks = 0;
  int errors = 0;

  ram_arbiter #(.AW(AW), .DW(DW), .PRIO_CPU(1'b0), .LOCK_MAX(4)) dut0 (
    .clk(clk), .reset(reset),
    .c_req(c_req), .c_we(c_we), .c_lock(c_lock), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt0), .c_rvalid(c_rv0),
    .d_req(d_req), .d_we(d_we), .d_lock(d_lock), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt0), .d_rvalid(d_rv0),
    .rdata(rdata0), .ram_chips(chips0), .ram_wrte(wrte0), .ram_adr(adr0),
    .ram_dout(dout0), .ram_drv(drv0), .ram_din(din0));

  ram_arbiter #(.AW(AW), .DW(DW), .PRIO_CPU(1'b1), .LOCK_MAX(3)) dut1 (
    .clk(clk), .reset(reset),
    .c_req(c_req), .c_we(c_we), .c_lock(c_lock), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt1), .c_rvalid(c_rv1),
    .d_req(d_req), .d_we(d_we), .d_lock(d_lock), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt1), .d_rvalid(d_rv1),
    .rdata(rdata1), .ram_chips(chips1), .ram_wrte(wrte1), .ram_adr(adr1),
    .ram_dout(dout1), .ram_drv(drv1), .ram_din(din1));

  // Level-sensitive RAM stand-ins: read data visible while selected for read, write taken at the edge.
  assign din0 = (chips0 && !wrte0) ? fx0[adr0] : '0;
  assign din1 = (chips1 && !wrte1) ? fx1[adr1] : '0;
  always @(posedge clk) begin
    if (chips0 && wrte0) fx0[adr0] <= dout0;
    if (chips1 && wrte1) fx1[adr1] <= dout1;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: per instance, the expected outputs plus the access now on the RAM.
  obs_t          exp_o [2];
  bit            m_busy [2];
  bit            m_last [2];
  int            m_cnt [2];
  bit            m_rd [2];
  bit            m_wr [2];
  bit            m_who [2];
  int            m_addr [2];
  logic [DW-1:0] m_data [2];
  logic [DW-1:0] mm [2][4096];

  function automatic int lock_max_of(int i);
    return (i == 0) ? 4 : 3;
  endfunction

  function automatic obs_t obs_of(int i);
    obs_t o;
    if (i == 0) o = {c_gnt0, d_gnt0, c_rv0, d_rv0, rdata0, chips0, wrte0, adr0, dout0, drv0};
    else        o = {c_gnt1, d_gnt1, c_rv1, d_rv1, rdata1, chips1, wrte1, adr1, dout1, drv1};
    return o;
  endfunction

  task automatic check(string tag, logic [31:0] got, logic [31:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  task automatic model_reset(int i);
    exp_o[i]  = '0;
    m_busy[i] = 1'b0;
    m_last[i] = 1'b1;
    m_cnt[i]  = 0;
    m_rd[i]   = 1'b0;
    m_wr[i]   = 1'b0;
  endtask

  task automatic model_step(int i);
    obs_t e;
    bit   win, who, keep;
    if (!reset) begin
      model_reset(i);
      return;
    end
    e = exp_o[i];
    // Retire the access that was on the RAM during the cycle just ended.
    e.c_rvalid = m_rd[i] && !m_who[i];
    e.d_rvalid = m_rd[i] && m_who[i];
    if (m_rd[i]) e.rdata = mm[i][m_addr[i]];
    if (m_wr[i]) mm[i][m_addr[i]] = m_data[i];
    // Pick the next winner.
    win  = 1'b1;
    who  = m_last[i];
    keep = m_busy[i] && (m_last[i] ? (d_req && d_lock) : (c_req && c_lock))
           && (m_cnt[i] < lock_max_of(i) - 1);
    if (keep)                 m_cnt[i] = m_cnt[i] + 1;
    else if (c_req && d_req)  who = (i == 1) ? 1'b0 : !m_last[i];
    else if (c_req || d_req)  who = d_req;
    else                      win = 1'b0;
    if (win && !keep && (who != m_last[i])) m_cnt[i] = 0;
    e.c_gnt = win && !who;
    e.d_gnt = win && who;
    e.chips = win;
    e.wrte  = win && (who ? d_we : c_we);
    e.drv   = e.wrte;
    if (win) begin
      e.adr     = who ? d_addr : c_addr;
      e.dout    = who ? d_wdata : c_wdata;
      m_last[i] = who;
    end
    m_busy[i] = win;
    m_rd[i]   = win && !e.wrte;
    m_wr[i]   = e.wrte;
    m_who[i]  = who;
    m_addr[i] = int'(e.adr);
    m_data[i] = e.dout;
    exp_o[i]  = e;
  endtask

  task automatic compare(int i);
    obs_t g, e;
    g = obs_of(i);
    e = exp_o[i];
    check($sformatf("u%0d.c_gnt", i),    32'(g.c_gnt),    32'(e.c_gnt));
    check($sformatf("u%0d.d_gnt", i),    32'(g.d_gnt),    32'(e.d_gnt));
    check($sformatf("u%0d.c_rvalid", i), 32'(g.c_rvalid), 32'(e.c_rvalid));
    check($sformatf("u%0d.d_rvalid", i), 32'(g.d_rvalid), 32'(e.d_rvalid));
    check($sformatf("u%0d.rdata", i),    32'(g.rdata),    32'(e.rdata));
    check($sformatf("u%0d.chips", i),    32'(g.chips),    32'(e.chips));
    check($sformatf("u%0d.wrte", i),     32'(g.wrte),     32'(e.wrte));
    check($sformatf("u%0d.adr", i),      32'(g.adr),      32'(e.adr));
    check($sformatf("u%0d.dout", i),     32'(g.dout),     32'(e.dout));
    check($sformatf("u%0d.drv", i),      32'(g.drv),      32'(e.drv));
  endtask

  task automatic tick();
    @(posedge clk);
    for (int i = 0; i < 2; i++) model_step(i);
    @(negedge clk);
    for (int i = 0; i < 2; i++) compare(i);
  endtask

  task automatic idle_inputs();
    c_req = 1'b0; c_we = 1'b0; c_lock = 1'b0; c_addr = '0; c_wdata = '0;
    d_req = 1'b0; d_we = 1'b0; d_lock = 1'b0; d_addr = '0; d_wdata = '0;
  endtask

  initial begin
    bit exp_d [6];
    exp_d = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    for (int a = 0; a < 4096; a++) begin
      fx0[a] = 4'(a); fx1[a] = 4'(a);
      mm[0][a] = 4'(a); mm[1][a] = 4'(a);
    end
    idle_inputs();
    model_reset(0);
    model_reset(1);

    // Reset held with both ports requesting: everything stays quiet.
    reset = 1'b1;
    c_req = 1'b1; d_req = 1'b1;
    #1 reset = 1'b0;
    #1 compare(0); compare(1);
    tick(); tick();
    reset = 1'b1;
    tick();
    check("rst_first_c_gnt", 32'(c_gnt0), 32'd1);
    check("rst_first_d_gnt", 32'(d_gnt0), 32'd0);
    idle_inputs();
    tick();

    // Core write to 0x123, then read it back.
    c_req = 1'b1; c_we = 1'b1; c_addr = 12'h123; c_wdata = 4'hA;
    tick();
    check("wr_chips", 32'(chips0), 32'd1);
    check("wr_wrte",  32'(wrte0),  32'd1);
    check("wr_drv",   32'(drv0),   32'd1);
    check("wr_adr",   32'(adr0),   32'h123);
    c_we = 1'b0;
    tick();
    check("rd_drv_low", 32'(drv0), 32'd0);
    c_req = 1'b0;
    tick();
    check("rd_rvalid", 32'(c_rv0),  32'd1);
    check("rd_rdata",  32'(rdata0), 32'hA);

    // Both ports requesting: alternation on u0, core always on u1 (C was last owner -> D first).
    c_req = 1'b1; d_req = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      check($sformatf("rr_c_gnt_%0d", k), 32'(c_gnt0), 32'(k % 2));
      check($sformatf("rr_d_gnt_%0d", k), 32'(d_gnt0), 32'((k + 1) % 2));
      check($sformatf("prio_c_gnt_%0d", k), 32'(c_gnt1), 32'd1);
      check($sformatf("prio_d_gnt_%0d", k), 32'(d_gnt1), 32'd0);
    end
    c_req = 1'b0;
    tick();
    check("prio_d_after_drop", 32'(d_gnt1), 32'd1);

    // D locks under contention: after C wins the first tie, D holds exactly 4 grants.
    idle_inputs();
    tick();
    c_req = 1'b1; d_req = 1'b1; d_lock = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      check($sformatf("lock_d_gnt_%0d", k), 32'(d_gnt0), 32'(exp_d[k]));
      check($sformatf("lock_c_gnt_%0d", k), 32'(c_gnt0), 32'(!exp_d[k]));
    end

    // Lock with the other port idle keeps granting past the limit.
    c_req = 1'b0;
    for (int k = 0; k < 6; k++) tick();
    idle_inputs();
    tick();

    // Randomised traffic over a small address window so reads hit earlier writes.
    for (int n = 0; n < 400; n++) begin
      c_req   = ($urandom_range(0, 3) != 0);
      d_req   = ($urandom_range(0, 2) != 0);
      c_we    = $urandom_range(0, 1) == 1;
      d_we    = $urandom_range(0, 1) == 1;
      c_lock  = ($urandom_range(0, 3) == 0);
      d_lock  = ($urandom_range(0, 2) == 0);
      c_addr  = 12'($urandom_range(0, 15));
      d_addr  = 12'($urandom_range(0, 15));
      c_wdata = 4'($urandom);
      d_wdata = 4'($urandom);
      tick();
    end
    idle_inputs();
    tick();

    // A request pulse that falls before the edge is never granted.
    d_req = 1'b1;
    #2 d_req = 1'b0;
    tick();
    check("cancel_d_gnt_u0", 32'(d_gnt0), 32'd0);
    check("cancel_d_gnt_u1", 32'(d_gnt1), 32'd0);

    // Reset in the middle of a write access drops the RAM controls at once.
    c_req = 1'b1; c_we = 1'b1; c_addr = 12'h055; c_wdata = 4'h5;
    tick();
    check("pre_rst_chips", 32'(chips0), 32'd1);
    c_req = 1'b0;
    #2 reset = 1'b0;
    #1;
    check("mid_rst_chips", 32'(chips0), 32'd0);
    check("mid_rst_wrte",  32'(wrte0),  32'd0);
    check("mid_rst_drv",   32'(drv0),   32'd0);
    model_reset(0);
    model_reset(1);
    compare(0); compare(1);
    tick(); tick();
    reset = 1'b1;
    tick(); tick();
    check("post_rst_c_rvalid", 32'(c_rv0), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
